// File: rtl/pattern_filler_pkg.sv
// pattern_filler_pkg -- shared definitions for the pattern_filler slice.
//   mode_e        : per-channel pattern mode encoding (matches cfg_mode)
//   fmt_shift()   : left-justification shift used to format data_word
//   rst_mode()    : reset-default mode for a channel index
//   rst_value()   : reset-default value for a channel index
// WALK mode is only implemented when PATTERN_FILLER_WALK_EN is defined.
package pattern_filler_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_UP    = 2'd1,
    MODE_DOWN  = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  // data_word carries one zero bit above the value.
  localparam int unsigned FMT_MSB_ZEROS = 1;

  // Number of zero bits below the value in data_word.
  function automatic int unsigned fmt_shift(input int unsigned word_w,
                                            input int unsigned data_w);
    return word_w - FMT_MSB_ZEROS - data_w;
  endfunction

  function automatic mode_e rst_mode(input int unsigned ch);
    case (ch)
      0:       return MODE_UP;
      1:       return MODE_DOWN;
      default: return MODE_CONST;
    endcase
  endfunction

  function automatic int unsigned rst_value(input int unsigned ch);
    case (ch)
      2:       return 111;
      3:       return 222;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/pattern_filler_chan.sv
// pattern_chan -- one pattern channel: mode, value, armed flag, step logic.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   arm_all    : frame start seen this cycle (arms the channel)
//   access     : this channel is read this cycle
//   cfg_load   : load cfg_mode/cfg_value into this channel
//   cfg_mode   : mode to load
//   cfg_value  : value/seed to load
//   value      : current value (pre-update during the access cycle)
// WALK stepping and the zero-seed fix-up exist only with PATTERN_FILLER_WALK_EN;
// otherwise mode 3 behaves as CONST.
module pattern_chan
  import pattern_filler_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter mode_e       RST_MODE  = MODE_CONST,
  parameter int unsigned RST_VALUE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm_all,
  input  logic              access,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_value,
  output logic [DATA_W-1:0] value
);

  localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(RST_VALUE);

  mode_e             mode_q;
  logic              armed;
  logic              armed_eff;
  logic [DATA_W-1:0] step_value;
  mode_e             load_mode;
  logic [DATA_W-1:0] load_value;

  always_comb begin
    // Arming from the frame start applies before the step in the same cycle,
    // so channel 0 steps on its rd_ptr == 0 access.
    armed_eff  = armed | arm_all;
    step_value = value;
    case (mode_q)
      MODE_UP:   step_value = value + DATA_W'(1);
      MODE_DOWN: step_value = value - DATA_W'(1);
`ifdef PATTERN_FILLER_WALK_EN
      MODE_WALK: step_value = {value[DATA_W-2:0], value[DATA_W-1]};
`endif
      default:   step_value = value;
    endcase

    load_mode  = mode_e'(cfg_mode);
    load_value = cfg_value;
`ifdef PATTERN_FILLER_WALK_EN
    // A walking-ones pattern needs a set bit to walk.
    if (load_mode == MODE_WALK && cfg_value == '0)
      load_value = DATA_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= RST_MODE;
      value  <= RST_VAL;
      armed  <= 1'b0;
    end else if (cfg_load) begin
      // Configuration overrides any step requested in the same cycle.
      mode_q <= load_mode;
      value  <= load_value;
      armed  <= 1'b0;
    end else if (access && armed_eff) begin
      value  <= step_value;
      armed  <= 1'b0;
    end else begin
      armed  <= armed_eff;
    end
  end

endmodule

// File: rtl/pattern_filler.sv
// pattern_filler -- multi-channel test-pattern word generator.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   get_word   : request one word this cycle
//   rd_ptr     : word position in frame; low bits select the channel
//   cfg_we     : configuration write strobe
//   cfg_ch     : channel addressed by cfg_we
//   cfg_mode   : 0 CONST, 1 UP, 2 DOWN, 3 WALK
//   cfg_value  : constant/seed value
//   data_word  : {1'b0, value, zeros}, registered
//   data_valid : one-cycle pulse when data_word is updated
// Define PATTERN_FILLER_WALK_EN to build WALK (rotate-left) mode.
module pattern_filler
  import pattern_filler_pkg::*;
#(
  parameter int unsigned WORD_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PTR_W  = 8,
  parameter int unsigned CH_N   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    get_word,
  input  logic [PTR_W-1:0]        rd_ptr,
  input  logic                    cfg_we,
  input  logic [$clog2(CH_N)-1:0] cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [DATA_W-1:0]       cfg_value,
  output logic [WORD_W-1:0]       data_word,
  output logic                    data_valid
);

  localparam int unsigned CH_W  = $clog2(CH_N);
  localparam int unsigned SHIFT = fmt_shift(WORD_W, DATA_W);

  logic [CH_W-1:0]   sel;
  logic              arm_all;
  logic [DATA_W-1:0] chan_value [CH_N];

  assign sel     = rd_ptr[CH_W-1:0];
  assign arm_all = get_word && (rd_ptr == '0);

  for (genvar i = 0; i < CH_N; i++) begin : g_chan
    pattern_chan #(
      .DATA_W    (DATA_W),
      .RST_MODE  (rst_mode(i)),
      .RST_VALUE (rst_value(i))
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .arm_all   (arm_all),
      .access    (get_word && (sel == CH_W'(i))),
      .cfg_load  (cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_mode  (cfg_mode),
      .cfg_value (cfg_value),
      .value     (chan_value[i])
    );
  end

  // chan_value is the pre-update value, so an access sees the old value and
  // any step/config lands on the next access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_word  <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= get_word;
      if (get_word)
        data_word <= WORD_W'(chan_value[sel]) << SHIFT;
    end
  end

endmodule
